// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types for the RAM-side arbiter
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, IGNT, DGNT, TURN} arb_state_t;
endpackage

// File: rtl/arb_timer.sv
// rtl/arb_timer.sv - 8-bit grant watchdog; expired once the count reaches TIMEOUT
module arb_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [7:0] count;

  assign expired = (count == 8'(TIMEOUT));

  // Saturates at TIMEOUT so a held expiry cannot wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && !expired)
      count <= count + 8'd1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin instruction/data arbiter in front of a variable-latency RAM
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int    TIMEOUT = 64,
  parameter word_t BAD     = 32'hBAD1BAD1
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      memerr
);
  arb_state_t state, next_state;
  word_t      rq_addr, rq_store;
  logic       rq_ren, rq_wen, lastd;
  logic       in_grant, access, abort, done, expired, d_pend, pick_d;

  assign in_grant = (state == IGNT) || (state == DGNT);
  assign access   = in_grant && (ramstate == ACCESS);
  assign abort    = in_grant && !access && ((ramstate == ERROR) || expired);
  assign done     = access || abort;
  assign d_pend   = dREN || dWEN;
  // Data wins unless instruction is also pending and data was served last.
  assign pick_d   = d_pend && (!iREN || !lastd);

  arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (CLK),
    .rst_n   (nRST),
    .clear   (!in_grant),
    .enable  (in_grant && (ramstate != ACCESS)),
    .expired (expired)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (pick_d) next_state = DGNT;
                  else if (iREN) next_state = IGNT;
      IGNT, DGNT: if (done) next_state = TURN;
      TURN:       next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rq_addr  <= '0;
      rq_store <= '0;
      rq_ren   <= 1'b0;
      rq_wen   <= 1'b0;
      lastd    <= 1'b0;
      memerr   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (pick_d) begin
          rq_addr  <= daddr;
          rq_store <= dstore;
          rq_wen   <= dWEN;
          rq_ren   <= dREN && !dWEN;
        end else if (iREN) begin
          rq_addr  <= iaddr;
          rq_ren   <= 1'b1;
          rq_wen   <= 1'b0;
        end
        if (dREN && dWEN)
          memerr <= 1'b1;
      end
      if (done)
        lastd <= (state == DGNT);
      if (abort)
        memerr <= 1'b1;
    end
  end

  always_comb begin
    ramREN   = in_grant && rq_ren;
    ramWEN   = in_grant && rq_wen;
    ramaddr  = rq_addr;
    ramstore = rq_store;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = BAD;
    dload    = BAD;
    if (done && state == IGNT) begin
      iwait = 1'b0;
      iload = access ? ramload : BAD;
    end
    if (done && state == DGNT) begin
      dwait = 1'b0;
      dload = access ? ramload : BAD;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - vector table, corner sequences and random transactions against a model
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int    TO = 4;
  localparam word_t B  = 32'hBAD1BAD1;

  logic      CLK = 1'b0, nRST = 1'b0;
  logic      iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  word_t     iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  ramstate_t ramstate = FREE;
  logic      iwait, dwait, ramREN, ramWEN, memerr;
  word_t     iload, dload, ramaddr, ramstore;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.TIMEOUT(TO), .BAD(B)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic iren; word_t iaddr; logic dren, dwen; word_t daddr, dstore;
    ramstate_t rs; word_t rl;
    logic e_ren, e_wen; word_t e_addr, e_store;
    logic e_iwait; word_t e_iload; logic e_dwait; word_t e_dload; logic e_err;
  } vec_t;

  function automatic vec_t mk(logic ir, word_t ia, logic dr, logic dw, word_t da, word_t ds,
                              ramstate_t rs, word_t rl, logic er, logic ew, word_t ea, word_t es,
                              logic eiw, word_t eil, logic edw, word_t edl, logic ee);
    vec_t v;
    v.iren = ir; v.iaddr = ia; v.dren = dr; v.dwen = dw; v.daddr = da; v.dstore = ds;
    v.rs = rs; v.rl = rl; v.e_ren = er; v.e_wen = ew; v.e_addr = ea; v.e_store = es;
    v.e_iwait = eiw; v.e_iload = eil; v.e_dwait = edw; v.e_dload = edl; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr_inputs();
    iREN = 0; dREN = 0; dWEN = 0; iaddr = '0; daddr = '0; dstore = '0;
    ramstate = FREE; ramload = '0;
  endtask

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  // Leaves the bench 1 time unit after a rising edge with the arbiter in IDLE.
  task automatic do_reset();
    clr_inputs();
    nRST = 0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1;
  endtask

  task automatic run_table();
    vec_t vt[14];
    vt[0]  = mk(1, 32'h40, 0, 0, 0, 0, FREE, 0,                    0, 0, 32'h0,   32'h0,        1, B, 1, B, 0);
    vt[1]  = mk(1, 32'h40, 0, 0, 0, 0, BUSY, 0,                    1, 0, 32'h40,  32'h0,        1, B, 1, B, 0);
    vt[2]  = mk(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'h8C010000,       1, 0, 32'h40,  32'h0,        0, 32'h8C010000, 1, B, 0);
    vt[3]  = mk(0, 0, 0, 0, 0, 0, FREE, 0,                         0, 0, 32'h40,  32'h0,        1, B, 1, B, 0);
    vt[4]  = mk(0, 0, 0, 0, 0, 0, FREE, 0,                         0, 0, 32'h40,  32'h0,        1, B, 1, B, 0);
    vt[5]  = mk(0, 0, 0, 1, 32'h100, 32'hDEADBEEF, FREE, 0,        0, 0, 32'h40,  32'h0,        1, B, 1, B, 0);
    vt[6]  = mk(0, 0, 0, 1, 32'h200, 32'h11111111, BUSY, 0,        0, 1, 32'h100, 32'hDEADBEEF, 1, B, 1, B, 0);
    vt[7]  = mk(0, 0, 0, 1, 32'h300, 32'h22222222, ACCESS, 32'h12345678, 0, 1, 32'h100, 32'hDEADBEEF, 1, B, 0, 32'h12345678, 0);
    vt[8]  = mk(0, 0, 0, 0, 0, 0, FREE, 0,                         0, 0, 32'h100, 32'hDEADBEEF, 1, B, 1, B, 0);
    vt[9]  = mk(0, 0, 0, 0, 0, 0, FREE, 0,                         0, 0, 32'h100, 32'hDEADBEEF, 1, B, 1, B, 0);
    vt[10] = mk(1, 32'h80, 0, 0, 0, 0, FREE, 0,                    0, 0, 32'h100, 32'hDEADBEEF, 1, B, 1, B, 0);
    vt[11] = mk(1, 32'h80, 0, 0, 0, 0, ERROR, 32'h55555555,        1, 0, 32'h80,  32'hDEADBEEF, 0, B, 1, B, 0);
    vt[12] = mk(0, 0, 0, 0, 0, 0, FREE, 0,                         0, 0, 32'h80,  32'hDEADBEEF, 1, B, 1, B, 1);
    vt[13] = mk(0, 0, 0, 0, 0, 0, FREE, 0,                         0, 0, 32'h80,  32'hDEADBEEF, 1, B, 1, B, 1);
    do_reset();
    for (int i = 0; i < 14; i++) begin
      iREN = vt[i].iren; iaddr = vt[i].iaddr; dREN = vt[i].dren; dWEN = vt[i].dwen;
      daddr = vt[i].daddr; dstore = vt[i].dstore; ramstate = vt[i].rs; ramload = vt[i].rl;
      @(negedge CLK);
      chk($sformatf("tbl%0d_ramREN", i),   ramREN,   vt[i].e_ren);
      chk($sformatf("tbl%0d_ramWEN", i),   ramWEN,   vt[i].e_wen);
      chk($sformatf("tbl%0d_ramaddr", i),  ramaddr,  vt[i].e_addr);
      chk($sformatf("tbl%0d_ramstore", i), ramstore, vt[i].e_store);
      chk($sformatf("tbl%0d_iwait", i),    iwait,    vt[i].e_iwait);
      chk($sformatf("tbl%0d_iload", i),    iload,    vt[i].e_iload);
      chk($sformatf("tbl%0d_dwait", i),    dwait,    vt[i].e_dwait);
      chk($sformatf("tbl%0d_dload", i),    dload,    vt[i].e_dload);
      chk($sformatf("tbl%0d_memerr", i),   memerr,   vt[i].e_err);
      next_cycle();
    end
  endtask

  task automatic run_reset_values();
    clr_inputs();
    iREN = 1; dREN = 1;
    nRST = 0;
    @(negedge CLK);
    chk("rst_ramREN", ramREN, 0);   chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0); chk("rst_ramstore", ramstore, 0);
    chk("rst_iwait", iwait, 1);     chk("rst_dwait", dwait, 1);
    chk("rst_iload", iload, B);     chk("rst_dload", dload, B);
    chk("rst_memerr", memerr, 0);
  endtask

  // Both ports always pending and RAM always ready: D, I, D, I with grant/TURN/IDLE spacing.
  task automatic run_contention();
    logic grant, is_d;
    do_reset();
    iREN = 1; dREN = 1; iaddr = 32'hA0; daddr = 32'hB0; ramstate = ACCESS; ramload = 32'h5A5A;
    for (int c = 0; c < 12; c++) begin
      grant = (c % 3 == 1);
      is_d  = ((c / 3) % 2 == 0);
      @(negedge CLK);
      chk($sformatf("cont%0d_ramREN", c), ramREN, grant);
      chk($sformatf("cont%0d_dwait", c), dwait, !(grant && is_d));
      chk($sformatf("cont%0d_iwait", c), iwait, !(grant && !is_d));
      if (grant) chk($sformatf("cont%0d_ramaddr", c), ramaddr, is_d ? 32'hB0 : 32'hA0);
      next_cycle();
    end
  endtask

  task automatic run_timeout();
    int hit = 0, ren_cycles = 0;
    word_t got = '0;
    do_reset();
    dREN = 1; daddr = 32'h44; ramstate = BUSY;
    for (int c = 0; c < 20 && hit == 0; c++) begin
      @(negedge CLK);
      if (ramREN) ren_cycles++;
      if (!dwait) begin hit = c; got = dload; end
      else next_cycle();
    end
    chk("tmo_abort_cycle", hit, TO + 1);
    chk("tmo_ren_cycles", ren_cycles, TO + 1);
    chk("tmo_dload", got, B);
    next_cycle();
    dREN = 0;
    @(negedge CLK);
    chk("tmo_turn_ramREN", ramREN, 0);
    chk("tmo_memerr", memerr, 1);
    repeat (3) next_cycle();
    @(negedge CLK);
    chk("tmo_memerr_sticky", memerr, 1);
  endtask

  task automatic run_both_flags();
    do_reset();
    dREN = 1; dWEN = 1; daddr = 32'h60; dstore = 32'h77; ramstate = ACCESS;
    next_cycle();
    @(negedge CLK);
    chk("rw_ramWEN", ramWEN, 1);
    chk("rw_ramREN", ramREN, 0);
    chk("rw_dwait", dwait, 0);
    next_cycle();
    dREN = 0; dWEN = 0;
    @(negedge CLK);
    chk("rw_memerr", memerr, 1);
  endtask

  task automatic run_reset_midgrant();
    do_reset();
    iREN = 1; iaddr = 32'h90; ramstate = BUSY;
    next_cycle();
    @(negedge CLK);
    chk("mid_granted", ramREN, 1);
    #1 nRST = 0;
    #1;
    chk("mid_ramREN", ramREN, 0);
    chk("mid_ramaddr", ramaddr, 0);
    chk("mid_iwait", iwait, 1);
    chk("mid_iload", iload, B);
    next_cycle();
    nRST = 1; ramstate = ACCESS; ramload = 32'hCAFEF00D;
    next_cycle();
    @(negedge CLK);
    chk("mid_after_iwait", iwait, 0);
    chk("mid_after_iload", iload, 32'hCAFEF00D);
    chk("mid_after_ramaddr", ramaddr, 32'h90);
    next_cycle();
    iREN = 0; ramstate = FREE;
    next_cycle();
  endtask

  // One requester at a time; model predicts end cycle, load and error flag from the RAM script.
  task automatic run_random();
    logic is_d, wr, both, exp_access, model_err, w, exp_ren, exp_wen;
    int lat, err_at, k_end, got_k, bad_side;
    word_t addr, data, rl, exp_load, got_load;
    do_reset();
    model_err = 0;
    for (int t = 0; t < 80; t++) begin
      is_d = 1'($urandom_range(0, 1));
      lat  = $urandom_range(0, 6);
      err_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : 0;
      both = is_d && ($urandom_range(0, 9) == 0);
      wr   = is_d && (both || $urandom_range(0, 1) == 1);
      addr = $urandom; data = $urandom; rl = $urandom;
      k_end = TO + 1;
      exp_access = 0;
      if (err_at != 0 && err_at < k_end) k_end = err_at;
      if (lat + 1 <= k_end) begin k_end = lat + 1; exp_access = 1; end
      exp_load = exp_access ? rl : B;
      exp_ren = !wr;
      exp_wen = wr;
      model_err = model_err | !exp_access | both;

      if (is_d) begin dREN = !wr || both; dWEN = wr; daddr = addr; dstore = data; end
      else begin iREN = 1; iaddr = addr; end
      ramstate = FREE; ramload = rl;
      got_k = 0; got_load = '0; bad_side = 0;
      @(negedge CLK);
      if (ramREN || ramWEN) bad_side++;
      for (int k = 1; k <= 20 && got_k == 0; k++) begin
        next_cycle();
        ramstate = (k == lat + 1) ? ACCESS : (k == err_at) ? ERROR : BUSY;
        if ($urandom_range(0, 1) == 1) begin iaddr = $urandom; daddr = $urandom; dstore = $urandom; end
        @(negedge CLK);
        if (ramREN !== exp_ren || ramWEN !== exp_wen || ramaddr !== addr) bad_side++;
        if (wr && ramstore !== data) bad_side++;
        w = is_d ? dwait : iwait;
        if ((is_d ? iwait : dwait) !== 1'b1) bad_side++;
        if (!w) begin got_k = k; got_load = is_d ? dload : iload; end
      end
      chk($sformatf("rnd%0d_end_cycle", t), got_k, k_end);
      chk($sformatf("rnd%0d_load", t), got_load, exp_load);
      chk($sformatf("rnd%0d_ram_side", t), bad_side, 0);
      next_cycle();
      clr_inputs();
      @(negedge CLK);
      chk($sformatf("rnd%0d_turn_idle", t), ramREN | ramWEN, 0);
      chk($sformatf("rnd%0d_memerr", t), memerr, model_err);
      next_cycle();
    end
  endtask

  initial begin
    run_reset_values();
    run_table();
    run_contention();
    run_timeout();
    run_both_flags();
    run_reset_midgrant();
    run_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
